// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: valid/ready controller that steps a 4-stage floating-point adder
// datapath with one-hot stage enables and bypasses it when either operand is zero.
module fp_add_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_valid_in,
  output logic                  start_ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  output logic [DATA_WIDTH-1:0] op1_out,
  output logic [DATA_WIDTH-1:0] op2_out,
  output logic [3:0]            stage_en_out,
  input  logic [DATA_WIDTH-1:0] result_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic                  busy_out,
  output logic [CNT_WIDTH-1:0]  op_count_out
);

  // state | meaning
  // IDLE  | ready for an operand pair
  // CMP   | exponent compare stage enabled
  // ALIGN | mantissa align stage enabled
  // ADD   | mantissa add stage enabled
  // NORM  | normalize stage enabled, result captured at end of cycle
  // DONE  | result presented, waiting for consumer
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int MAG_W = EXPO_WIDTH + MENT_WIDTH;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CNT_WIDTH-1:0]  r_op_count;
  logic                  w_accept;
  logic                  w_op1_zero;
  logic                  w_op2_zero;
  logic [3:0]            w_stage_en;
  logic                  w_start_ready;
  logic                  w_result_valid;
  logic                  w_busy;

  // Sign is ignored so that -0 also takes the bypass.
  assign w_op1_zero = (floating1_in[MAG_W-1:0] == '0);
  assign w_op2_zero = (floating2_in[MAG_W-1:0] == '0);
  assign w_accept   = (r_state == S_IDLE) && start_valid_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start_valid_in) begin
          w_next_state = (w_op1_zero || w_op2_zero) ? S_DONE : S_CMP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CMP:   w_next_state = S_ALIGN;
      S_ALIGN: w_next_state = S_ADD;
      S_ADD:   w_next_state = S_NORM;
      S_NORM:  w_next_state = S_DONE;
      S_DONE:  w_next_state = result_ready_in ? S_IDLE : S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_stage_en     = 4'b0000;
    w_start_ready  = 1'b0;
    w_result_valid = 1'b0;
    w_busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_start_ready = 1'b1;
        w_busy        = 1'b0;
      end
      S_CMP:   w_stage_en = 4'b0001;
      S_ALIGN: w_stage_en = 4'b0010;
      S_ADD:   w_stage_en = 4'b0100;
      S_NORM:  w_stage_en = 4'b1000;
      S_DONE:  w_result_valid = 1'b1;
      default: w_stage_en = 4'b0000;
    endcase
  end

  // Operands only load in IDLE, so they stay stable for the whole operation.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_result   <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_op1 <= floating1_in;
        r_op2 <= floating2_in;
        if (w_op1_zero) begin
          r_result <= floating2_in;
        end else if (w_op2_zero) begin
          r_result <= floating1_in;
        end
      end
      if (r_state == S_NORM) begin
        r_result <= result_in;
      end
      if ((r_state == S_DONE) && result_ready_in) begin
        r_op_count <= r_op_count + CNT_WIDTH'(1);
      end
    end
  end

  assign start_ready_out  = w_start_ready;
  assign op1_out          = r_op1;
  assign op2_out          = r_op2;
  assign stage_en_out     = w_stage_en;
  assign result_out       = r_result;
  assign result_valid_out = w_result_valid;
  assign busy_out         = w_busy;
  assign op_count_out     = r_op_count;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a stub normalizer; expected values are
// hand-computed constants or derived from the documented latency/issue intervals.
module tb_fp_add_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_valid_in = 1'b0;
  logic        result_ready_in = 1'b0;
  logic [31:0] floating1_in = '0;
  logic [31:0] floating2_in = '0;
  logic [31:0] result_in;
  logic        start_ready_out;
  logic [31:0] op1_out;
  logic [31:0] op2_out;
  logic [3:0]  stage_en_out;
  logic [31:0] result_out;
  logic        result_valid_out;
  logic        busy_out;
  logic [15:0] op_count_out;

  logic        use_fixed = 1'b1;
  logic [31:0] fixed_val = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk_in = ~clk_in;

  // Stub normalizer: a fixed value, or a plain integer sum so each result identifies its pair.
  assign result_in = stage_en_out[3] ? (use_fixed ? fixed_val : op1_out + op2_out) : 32'hDEADBEEF;

  fp_add_sequencer dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start_valid_in  (start_valid_in),
    .start_ready_out (start_ready_out),
    .floating1_in    (floating1_in),
    .floating2_in    (floating2_in),
    .op1_out         (op1_out),
    .op2_out         (op2_out),
    .stage_en_out    (stage_en_out),
    .result_in       (result_in),
    .result_out      (result_out),
    .result_valid_out(result_valid_out),
    .result_ready_in (result_ready_in),
    .busy_out        (busy_out),
    .op_count_out    (op_count_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle k+1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    floating1_in   = a;
    floating2_in   = b;
    start_valid_in = 1'b1;
    @(negedge clk_in);
    start_valid_in = 1'b0;
  endtask

  task automatic normal_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic [15:0] exp_cnt);
    start_op(a, b);
    check({tag, "_op1"}, op1_out, a);
    check({tag, "_op2"}, op2_out, b);
    check({tag, "_busy"}, busy_out, 1);
    check({tag, "_sready"}, start_ready_out, 0);
    for (int s = 0; s < 4; s++) begin
      check({tag, "_stage"}, stage_en_out, 32'(1 << s));
      check({tag, "_nvalid"}, result_valid_out, 0);
      @(negedge clk_in);
    end
    check({tag, "_valid"}, result_valid_out, 1);
    check({tag, "_res"}, result_out, exp);
    check({tag, "_stage_done"}, stage_en_out, 0);
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    check({tag, "_cnt"}, op_count_out, exp_cnt);
    check({tag, "_idle"}, start_ready_out, 1);
    check({tag, "_vlow"}, result_valid_out, 0);
  endtask

  task automatic bypass_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic [15:0] exp_cnt);
    start_op(a, b);
    check({tag, "_valid"}, result_valid_out, 1);
    check({tag, "_res"}, result_out, exp);
    check({tag, "_stage"}, stage_en_out, 0);
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    check({tag, "_cnt"}, op_count_out, exp_cnt);
    check({tag, "_idle"}, start_ready_out, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a6, b6, exp_res6;
    int          next_acc, done_cyc, guard;

    // Reset values
    repeat (2) @(negedge clk_in);
    check("rst_sready", start_ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_stage", stage_en_out, 0);
    check("rst_valid", result_valid_out, 0);
    check("rst_res", result_out, 0);
    check("rst_cnt", op_count_out, 0);
    reset_in = 1'b0;
    @(negedge clk_in);

    // 1) normal path
    use_fixed = 1'b1;
    fixed_val = 32'h40400000;
    normal_op("t1", 32'h3F800000, 32'h40000000, 32'h40400000, 16'd1);

    // 2) zero bypass, including -0 and both-zero
    bypass_op("t2a", 32'h80000000, 32'h40490FDB, 32'h40490FDB, 16'd2);
    bypass_op("t2b", 32'h3F800000, 32'h00000000, 32'h3F800000, 16'd3);
    bypass_op("t2c", 32'h00000000, 32'h80000000, 32'h80000000, 16'd4);

    // 3) backpressure in DONE; start pulse must not be captured
    fixed_val = 32'h12345678;
    start_op(32'h3F800000, 32'h40000000);
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      check("t3_valid", result_valid_out, 1);
      check("t3_res", result_out, 32'h12345678);
      check("t3_sready", start_ready_out, 0);
      if (i == 1) begin
        floating1_in   = 32'h11111111;
        floating2_in   = 32'h22222222;
        start_valid_in = 1'b1;
      end
      @(negedge clk_in);
      start_valid_in = 1'b0;
    end
    check("t3_op1_held", op1_out, 32'h3F800000);
    check("t3_op2_held", op2_out, 32'h40000000);
    check("t3_cnt_held", op_count_out, 16'd4);
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    check("t3_cnt", op_count_out, 16'd5);
    check("t3_idle", start_ready_out, 1);

    // 4) reset during ALIGN
    fixed_val = 32'h40400000;
    start_op(32'h40000000, 32'h40400000);
    @(negedge clk_in);
    check("t4_align", stage_en_out, 4'b0010);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    check("t4_sready", start_ready_out, 1);
    check("t4_busy", busy_out, 0);
    check("t4_stage", stage_en_out, 0);
    check("t4_valid", result_valid_out, 0);
    check("t4_op1", op1_out, 0);
    check("t4_op2", op2_out, 0);
    check("t4_res", result_out, 0);
    check("t4_cnt", op_count_out, 0);
    @(negedge clk_in);
    check("t4_still_idle", stage_en_out, 0);
    normal_op("t4n", 32'h3F800000, 32'h40000000, 32'h40400000, 16'd1);

    // 5) counter wrap
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk_in);
    release dut.r_op_count;
    check("t5_pre", op_count_out, 16'hFFFF);
    bypass_op("t5", 32'h3F800000, 32'h00000000, 32'h3F800000, 16'h0000);

    // 6) back-to-back with start_valid held high and operands changing every cycle
    use_fixed       = 1'b0;
    result_ready_in = 1'b1;
    start_valid_in  = 1'b1;
    next_acc        = 0;
    done_cyc        = -1;
    exp_res6        = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        check("t6_sready", start_ready_out, (c == next_acc) ? 1 : 0);
        check("t6_valid", result_valid_out, (c == done_cyc) ? 1 : 0);
        if (c == done_cyc) check("t6_res", result_out, exp_res6);
      end
      a6 = ((c % 4) == 0) ? 32'h00000000 : 32'h3F800000 + 32'(c);
      b6 = 32'h40000000 + 32'(c * 16);
      floating1_in = a6;
      floating2_in = b6;
      if (c == next_acc) begin
        if (a6 == 0) begin
          exp_res6 = b6;
          done_cyc = c + 1;
          next_acc = c + 2;
        end else begin
          exp_res6 = a6 + b6;
          done_cyc = c + 5;
          next_acc = c + 6;
        end
      end
      @(negedge clk_in);
    end
    start_valid_in = 1'b0;
    guard = 0;
    while (busy_out && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    check("t6_drain", busy_out, 0);
    result_ready_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
